// File: rtl/duty_sweep_ctrl.sv
// Duty-code sweep sequencer: steps duty_code through sawtooth or triangle sweeps
// with programmable range, step, per-code dwell and sweep count.
module duty_sweep_ctrl #(
  parameter int CODE_W  = 8,
  parameter int DWELL_W = 16,
  parameter int NSW_W   = 8
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic [CODE_W-1:0]  code_lo,
  input  logic [CODE_W-1:0]  code_hi,
  input  logic [CODE_W-1:0]  step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [NSW_W-1:0]   n_sweeps,
  output logic [CODE_W-1:0]  duty_code,
  output logic               step_strobe,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;

  state_t              state;
  logic                cfg_mode;
  logic [CODE_W-1:0]   cfg_lo;
  logic [CODE_W-1:0]   cfg_hi;
  logic [CODE_W-1:0]   cfg_step;
  logic [DWELL_W-1:0]  cfg_dwell;
  logic [NSW_W-1:0]    cfg_nsw;
  logic [DWELL_W-1:0]  dwell_cnt;
  logic [NSW_W-1:0]    sweeps_left;

  logic [CODE_W:0]     up_sum;
  logic [CODE_W:0]     rs_sum;
  logic [CODE_W-1:0]   up_code;
  logic [CODE_W-1:0]   dn_code;
  logic [CODE_W-1:0]   rs_code;
  logic [CODE_W-1:0]   dn_room;
  logic                up_end;
  logic                dn_end;
  logic                sweep_end;
  logic                last_sweep;

  // Next-code candidates, all saturating at the latched bounds.
  always_comb begin
    up_sum  = {1'b0, duty_code} + {1'b0, cfg_step};
    rs_sum  = {1'b0, cfg_lo} + {1'b0, cfg_step};
    dn_room = duty_code - cfg_lo;
    up_code = (up_sum >= {1'b0, cfg_hi}) ? cfg_hi : up_sum[CODE_W-1:0];
    dn_code = (cfg_step >= dn_room) ? cfg_lo : duty_code - cfg_step;
    if (!cfg_mode) rs_code = cfg_lo;
    else           rs_code = (rs_sum >= {1'b0, cfg_hi}) ? cfg_hi : rs_sum[CODE_W-1:0];
    up_end     = (duty_code == cfg_hi);
    dn_end     = (duty_code == cfg_lo);
    // A triangle with lo == hi has no down-leg: the single code ends the sweep.
    sweep_end  = (state == DOWN) ? dn_end : (up_end && (!cfg_mode || dn_end));
    last_sweep = (cfg_nsw != '0) && (sweeps_left == NSW_W'(1));
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= IDLE;
      cfg_mode    <= 1'b0;
      cfg_lo      <= '0;
      cfg_hi      <= '0;
      cfg_step    <= '0;
      cfg_dwell   <= '0;
      cfg_nsw     <= '0;
      dwell_cnt   <= '0;
      sweeps_left <= '0;
      duty_code   <= '0;
      step_strobe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if ((code_lo > code_hi) || (step == '0)) begin
              cfg_err <= 1'b1;
            end else begin
              cfg_mode    <= mode;
              cfg_lo      <= code_lo;
              cfg_hi      <= code_hi;
              cfg_step    <= step;
              cfg_dwell   <= dwell;
              cfg_nsw     <= n_sweeps;
              dwell_cnt   <= dwell;
              sweeps_left <= n_sweeps;
              duty_code   <= code_lo;
              step_strobe <= 1'b1;
              busy        <= 1'b1;
              state       <= UP;
            end
          end
        end
        UP, DOWN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (dwell_cnt != '0) begin
            dwell_cnt <= dwell_cnt - DWELL_W'(1);
          end else if (sweep_end) begin
            if (last_sweep) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              if (cfg_nsw != '0) sweeps_left <= sweeps_left - NSW_W'(1);
              duty_code   <= rs_code;
              step_strobe <= 1'b1;
              dwell_cnt   <= cfg_dwell;
              state       <= UP;
            end
          end else begin
            step_strobe <= 1'b1;
            dwell_cnt   <= cfg_dwell;
            if ((state == UP) && !up_end) begin
              duty_code <= up_code;
            end else begin
              duty_code <= dn_code;
              state     <= DOWN;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_duty_sweep_ctrl.sv
// Bench for duty_sweep_ctrl: a list-based sweep model predicts every cycle's outputs,
// pinned against hand-computed code sequences.
module tb_duty_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rstb = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  code_lo = '0;
  logic [7:0]  code_hi = '0;
  logic [7:0]  step = '0;
  logic [15:0] dwell = '0;
  logic [7:0]  n_sweeps = '0;
  logic [7:0]  duty_code;
  logic        step_strobe;
  logic        busy;
  logic        done;
  logic        cfg_err;

  always #5 clk = ~clk;

  duty_sweep_ctrl #(.CODE_W(8), .DWELL_W(16), .NSW_W(8)) dut (
    .clk(clk), .rstb(rstb), .start(start), .abort(abort), .mode(mode),
    .code_lo(code_lo), .code_hi(code_hi), .step(step), .dwell(dwell),
    .n_sweeps(n_sweeps), .duty_code(duty_code), .step_strobe(step_strobe),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  typedef struct packed {
    logic [7:0] code;
    logic       strobe;
    logic       busy;
    logic       done;
    logic       err;
  } exp_t;

  exp_t       q[$];
  exp_t       trace[$];
  logic [7:0] hold;
  int         checks = 0;
  int         errors = 0;
  bit         chk_en = 1'b0;
  int         stb_cnt, busy_cnt, done_cnt, err_cnt;
  int         pa[$];

  task automatic compare_cycle();
    exp_t        e;
    logic [11:0] got;
    if (q.size() != 0) e = q.pop_front();
    else               e = {hold, 4'b0000};
    got = {duty_code, step_strobe, busy, done, cfg_err};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL cycle t=%0t got code=%0d stb=%b busy=%b done=%b err=%b want code=%0d stb=%b busy=%b done=%b err=%b",
               $time, duty_code, step_strobe, busy, done, cfg_err,
               e.code, e.strobe, e.busy, e.done, e.err);
    end
    stb_cnt  += int'(step_strobe);
    busy_cnt += int'(busy);
    done_cnt += int'(done);
    err_cnt  += int'(cfg_err);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (chk_en) compare_cycle();
    #1;
  endtask

  task automatic clear_counts();
    stb_cnt = 0; busy_cnt = 0; done_cnt = 0; err_cnt = 0;
  endtask

  task automatic expect_int(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic cfg(input int md, input int lo, input int hi, input int st,
                     input int dw, input int ns);
    mode = md[0]; code_lo = 8'(lo); code_hi = 8'(hi); step = 8'(st);
    dwell = 16'(dw); n_sweeps = 8'(ns);
  endtask

  // Sweep model: list the codes each sweep visits, expand by dwell, append done.
  task automatic build(input int md, input int lo, input int hi, input int st,
                       input int dw, input int nsw, input int trunc);
    int   codes[$];
    int   c;
    int   ns;
    exp_t e;
    trace.delete();
    ns = (nsw == 0) ? 3 : nsw;
    for (int s = 0; s < ns; s++) begin
      if (lo == hi) begin
        codes.push_back(lo);
        continue;
      end
      c = lo;
      if (!(md != 0 && s > 0)) codes.push_back(c);
      while (c != hi) begin
        c = (c + st > hi) ? hi : c + st;
        codes.push_back(c);
      end
      if (md != 0) begin
        while (c != lo) begin
          c = (c - st < lo) ? lo : c - st;
          codes.push_back(c);
        end
      end
    end
    foreach (codes[i]) begin
      for (int d = 0; d <= dw; d++) begin
        e.code = 8'(codes[i]); e.strobe = (d == 0); e.busy = 1'b1;
        e.done = 1'b0; e.err = 1'b0;
        trace.push_back(e);
      end
    end
    if (trunc > 0) begin
      while (trace.size() > trunc) void'(trace.pop_back());
    end
    hold = trace[trace.size()-1].code;
    if (trunc == 0) begin
      e = trace[trace.size()-1];
      e.strobe = 1'b0; e.busy = 1'b0; e.done = 1'b1;
      trace.push_back(e);
    end
    foreach (trace[i]) q.push_back(trace[i]);
  endtask

  task automatic pin(input string nm, input int want[$]);
    int n = 0;
    foreach (trace[i]) begin
      if (trace[i].busy) begin
        checks++;
        if (n >= want.size() || int'(trace[i].code) != want[n]) begin
          errors++;
          $display("FAIL pin_%s[%0d] model=%0d literal=%0d", nm, n, trace[i].code,
                   (n < want.size()) ? want[n] : -1);
        end
        n++;
      end
    end
    expect_int({"pin_len_", nm}, n, want.size());
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d want=0", q.size());
      q.delete();
    end
  endtask

  initial begin
    exp_t e;
    #1;
    rstb = 1'b0;
    hold = '0;
    chk_en = 1'b1;
    repeat (2) tick();
    expect_int("reset_outputs", int'({duty_code, step_strobe, busy, done, cfg_err}), 0);
    rstb = 1'b1;
    repeat (2) tick();

    // Sawtooth single sweep, with an ignored start and input changes mid-sweep
    cfg(0, 10, 20, 4, 1, 1);
    build(0, 10, 20, 4, 1, 1, 0);
    pa = {10, 10, 14, 14, 18, 18, 20, 20};
    pin("saw", pa);
    clear_counts();
    start = 1'b1; tick(); start = 1'b0;
    repeat (2) tick();
    start = 1'b1; mode = 1'b1; code_lo = 8'd0; code_hi = 8'd99; step = 8'd1;
    tick();
    start = 1'b0;
    wait_drain();
    repeat (2) tick();
    expect_int("saw_strobes", stb_cnt, 4);
    expect_int("saw_busy_cycles", busy_cnt, 8);
    expect_int("saw_done", done_cnt, 1);
    expect_int("saw_final_code", int'(duty_code), 20);

    // Triangle two sweeps; start coincident with abort in IDLE
    cfg(1, 0, 6, 3, 0, 2);
    build(1, 0, 6, 3, 0, 2, 0);
    pa = {0, 3, 6, 3, 0, 3, 6, 3, 0};
    pin("tri", pa);
    clear_counts();
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    wait_drain();
    repeat (2) tick();
    expect_int("tri_strobes", stb_cnt, 9);
    expect_int("tri_busy_cycles", busy_cnt, 9);
    expect_int("tri_done", done_cnt, 1);

    // Saturation at the top of the code range
    cfg(0, 250, 255, 200, 0, 1);
    build(0, 250, 255, 200, 0, 1, 0);
    pa = {250, 255};
    pin("sat", pa);
    clear_counts();
    start = 1'b1; tick(); start = 1'b0;
    wait_drain();
    repeat (2) tick();
    expect_int("sat_done", done_cnt, 1);
    expect_int("sat_final_code", int'(duty_code), 255);

    // Rejected starts: inverted range, then zero step
    clear_counts();
    cfg(0, 30, 20, 4, 0, 1);
    e = {hold, 4'b0001};
    q.push_back(e);
    start = 1'b1; tick(); start = 1'b0;
    repeat (2) tick();
    cfg(0, 5, 9, 0, 0, 1);
    q.push_back(e);
    start = 1'b1; tick(); start = 1'b0;
    wait_drain();
    repeat (2) tick();
    expect_int("cfg_err_pulses", err_cnt, 2);
    expect_int("cfg_err_busy", busy_cnt, 0);
    expect_int("cfg_err_code", int'(duty_code), 255);

    // Continuous triangle aborted while dwelling at 14
    cfg(1, 10, 20, 4, 3, 0);
    build(1, 10, 20, 4, 3, 0, 6);
    pa = {10, 10, 10, 10, 14, 14};
    pin("abort", pa);
    clear_counts();
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    abort = 1'b1; tick();
    repeat (2) tick();
    abort = 1'b0;
    repeat (2) tick();
    expect_int("abort_done", done_cnt, 0);
    expect_int("abort_busy_cycles", busy_cnt, 6);
    expect_int("abort_code", int'(duty_code), 14);

    // Restart after abort, then asynchronous reset mid-sweep
    cfg(0, 40, 100, 10, 2, 3);
    build(0, 40, 100, 10, 2, 3, 0);
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    #2;
    rstb = 1'b0;
    q.delete();
    hold = '0;
    #1;
    expect_int("async_reset", int'({duty_code, step_strobe, busy, done, cfg_err}), 0);
    repeat (2) tick();
    rstb = 1'b1;
    repeat (2) tick();

    // Degenerate range in triangle mode after reset
    cfg(1, 77, 77, 5, 2, 2);
    build(1, 77, 77, 5, 2, 2, 0);
    pa = {77, 77, 77, 77, 77, 77};
    pin("degen", pa);
    clear_counts();
    start = 1'b1; tick(); start = 1'b0;
    wait_drain();
    repeat (2) tick();
    expect_int("degen_strobes", stb_cnt, 2);
    expect_int("degen_done", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/duty_sweep_ctrl.md
Name: duty_sweep_ctrl

Overview:
- Digital sequencer that steps the duty-cycle code feeding the duty-to-clock converter through programmed sweeps.
- Replaces the free-running sine duty source in duty-modulation characterisation benches.
- Supports sawtooth or triangle sweeps with a programmable range, step size, per-step dwell and sweep count.
- Provides a start/abort handshake and busy/done status; `duty_code` drives the duty DAC/xreal mapper upstream of the clock generator.

Parameters:
- CODE_W, 8, width of duty code and range/step fields
- DWELL_W, 16, width of dwell counter
- NSW_W, 8, width of sweep-count field

Ports:
- clk  in  1  system clock
- rstb  in  1  asynchronous active-low reset
- start  in  1  request a sweep; sampled only in IDLE
- abort  in  1  terminate a running sweep
- mode  in  1  0 = sawtooth, 1 = triangle
- code_lo  in  CODE_W  lower sweep bound
- code_hi  in  CODE_W  upper sweep bound
- step  in  CODE_W  code increment per step
- dwell  in  DWELL_W  each code is held for dwell+1 cycles
- n_sweeps  in  NSW_W  number of sweeps; 0 = continuous until abort
- duty_code  out  CODE_W  current duty code
- step_strobe  out  1  one-cycle pulse whenever duty_code is loaded
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse on normal completion
- cfg_err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Clock and reset: one clock domain.
  - rstb low asynchronously forces state IDLE and all counters to 0.
  - Reset values: duty_code=0, step_strobe=0, busy=0, done=0, cfg_err=0.
  - Reset asserted mid-sweep aborts the sweep immediately; no done pulse.
- States: IDLE, UP, DOWN, DONE.
- Configuration latch: on start in IDLE, all configuration inputs are latched. Later input changes have no effect until the next start.
- Start rejection: if code_lo > code_hi or step == 0, pulse cfg_err for 1 cycle and remain in IDLE. duty_code is unchanged.
- Start acceptance:
  - The edge that samples start loads duty_code=code_lo and pulses step_strobe.
  - busy=1 from that edge; state goes to UP.
  - Dwell counter is loaded with dwell.
- Dwell: each code is held for exactly dwell+1 cycles; the counter decrements to 0, then the step is taken.
- UP step:
  - next = code+step, computed in CODE_W+1 bits so there is no wrap-around.
  - If next ≥ code_hi, load code_hi (saturate).
  - If the current code already equals code_hi, the up-leg ends.
- Up-leg end:
  - Sawtooth: sweep complete.
  - Triangle: go to DOWN and load max(code−step, code_lo), using the same saturation rule downward (no underflow).
- DOWN: when the current code equals code_lo at dwell expiry, sweep complete.
- Sweep complete with sweeps remaining (or n_sweeps=0):
  - Sawtooth: load code_lo, state UP.
  - Triangle: load min(code_lo+step, code_hi), state UP; code_lo is not repeated.
- Degenerate range code_lo == code_hi: each sweep is a single dwell at that code, in either mode.
- Last sweep complete:
  - Next edge: state DONE, done=1, busy=0; duty_code holds its final value.
  - Following edge: IDLE, done=0.
- abort:
  - Valid in UP or DOWN; takes priority over dwell expiry in the same cycle.
  - Next edge: IDLE, busy=0, no done pulse, no step_strobe; duty_code holds.
  - abort in IDLE or DONE is ignored.
- start while busy or in DONE is ignored; it is not queued.
- A start arriving with abort in IDLE is processed normally.
- step_strobe pulses exactly on cycles where duty_code takes a newly loaded value, including the first load and reloads of an equal value.

Test Plan:
- Sawtooth, single sweep:
  - Stimulus: mode=0, lo=10, hi=20, step=4, dwell=1, n_sweeps=1, start pulse.
  - Required: duty_code 10,10,14,14,18,18,20,20; 4 step_strobes; busy high 8 cycles; done pulses on the 9th cycle with busy=0; duty_code stays 20.
- Triangle, two sweeps:
  - Stimulus: mode=1, lo=0, hi=6, step=3, dwell=0, n_sweeps=2.
  - Required: codes 0,3,6,3,0,3,6,3,0 one cycle each, then done; 9 strobes.
- Saturation and no overflow:
  - Stimulus: CODE_W=8, lo=250, hi=255, step=200, sawtooth, dwell=0, n_sweeps=1.
  - Required: codes 250,255, then done; no wrap to a low value.
- Config error:
  - Stimulus: lo=30, hi=20 → one cfg_err pulse, busy stays 0. Repeat with step=0 → same result.
  - Required: duty_code unchanged in both cases.
- Abort and continuous mode:
  - Stimulus: n_sweeps=0, triangle, abort asserted mid-dwell at code 14.
  - Required: next cycle busy=0, done never pulses, duty_code=14; a new start is accepted afterwards.
- Reset mid-operation and ignored start:
  - Stimulus: start pulse while busy → no restart, sequence continues unchanged. Then rstb low mid-sweep.
  - Required: all outputs 0 immediately (asynchronous, before the next clock edge); after release, state is IDLE.
